regfile_golden_checker: RTL
===========================

Name: regfile_golden_checker

Overview:
- Synthesizable end-of-test checker that sits beside cpu_top and taps the flattened architectural register file.
- Waits for a configurable completion signature in one register, bounded by a timeout.
- Snapshots all registers, then compares them one per cycle against a golden memory port, with per-entry skip.
- Reports pass/fail, timeout, mismatch count and details of the first mismatch. Usable in simulation and on FPGA.

Parameters:
- XLEN, 32, register width.
- NUM_REGS, 32, number of registers tapped and compared (>=2).
- SIG_REG, 11, index of the completion-signature register.
- SIG_VALUE, 32'h0000C0DE, completion value (XLEN bits).
- TIMEOUT_CYCLES, 50, maximum WAIT cycles; 0 disables the timeout.
- CNT_W, 16, width of the wait-cycle counter.
- IDX_W, $clog2(NUM_REGS), derived localparam, not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  arm pulse; honoured only in IDLE or FIN.
- reg_flat  in  NUM_REGS*XLEN  register i is on [i*XLEN +: XLEN].
- gold_rd  out  1  golden read strobe.
- gold_addr  out  IDX_W  golden entry index.
- gold_data  in  XLEN  golden value, valid exactly 1 cycle after gold_rd.
- gold_valid  in  1  qualifies gold_data; 0 means skip this entry.
- busy  out  1  high in WAIT and CMP.
- done  out  1  high in FIN, sticky until start or reset.
- pass  out  1  meaningful while done=1.
- timeout  out  1  signature never seen within TIMEOUT_CYCLES.
- mismatch_count  out  IDX_W+1  number of failing entries.
- first_bad_idx  out  IDX_W  index of the first failing entry.
- first_bad_exp  out  XLEN  golden value of the first failing entry.
- first_bad_act  out  XLEN  snapshot value of the first failing entry.
- wait_cycles  out  CNT_W  cycles spent in WAIT.

Behaviour:
- Reset (async, any state): state=IDLE. Every output, the snapshot buffer and all counters go to 0.
- States: IDLE, WAIT, CMP, FIN. All outputs are registered.
- IDLE:
  - start=1 -> WAIT on that edge.
  - Clear wait_cycles, timeout, mismatch_count and all first_bad_* outputs. pass=0.
- WAIT, evaluated each edge:
  - If reg_flat[SIG_REG] == SIG_VALUE: capture all NUM_REGS registers into the snapshot, go to CMP with rd_idx=0.
  - Else if TIMEOUT_CYCLES!=0 and wait_cycles+1 == TIMEOUT_CYCLES: set timeout=1, capture the snapshot, go to CMP.
  - Else wait_cycles++, saturating at all-ones.
  - Signature match takes priority over timeout on the same edge.
- CMP, two-stage pipeline:
  - Issue stage: gold_rd=1, gold_addr=rd_idx, for rd_idx = 0..NUM_REGS-1 on consecutive cycles.
  - Compare stage, one cycle later: the entry is bad if gold_valid=1 and gold_data != snapshot[idx].
  - Each bad entry increments mismatch_count. On the first bad entry only, latch first_bad_idx, first_bad_exp and first_bad_act.
  - gold_rd=0 after the last issue.
  - The last compare occurs NUM_REGS cycles after CMP entry. On the next edge go to FIN, so CMP lasts NUM_REGS+1 cycles.
- FIN:
  - done=1, busy=0.
  - pass = (mismatch_count==0) && !timeout, using the count that includes the final compare.
  - start=1 -> clear results as in IDLE and go to WAIT.
- start while in WAIT or CMP is ignored.
- The snapshot isolates the comparison from later register writes by the running CPU.
- Entry 0 is compared like any other entry; the golden memory supplies the expected x0 value.
- mismatch_count cannot overflow: its maximum value NUM_REGS fits in IDX_W+1 bits.

Test Plan:
1. Signature seen in register 11 at WAIT cycle 10; golden matches every entry -> wait_cycles=10, done asserted NUM_REGS+1 (33) cycles after leaving WAIT, pass=1, mismatch_count=0, timeout=0.
2. Golden entry 5 = 0x00000007 vs actual 0x00000006, and entry 20 also differs -> mismatch_count=2, first_bad_idx=5, first_bad_exp=0x7, first_bad_act=0x6, pass=0.
3. Signature never appears, TIMEOUT_CYCLES=50 -> timeout=1 after 50 WAIT cycles; comparison still runs; pass=0 even with an all-matching golden.
4. Entry 7 mismatches but gold_valid=0 on it -> entry skipped, mismatch_count=0, pass=1.
5. Bench changes register 3 the cycle after the signature -> the snapshot value is compared, pass=1; start pulse during CMP is ignored.
6. reset pulsed at CMP cycle 10 -> all outputs 0 and state IDLE immediately. A new start gives a clean run reproducing scenario 1.

Source files
------------

// File: rtl/regfile_golden_checker.sv
// regfile_golden_checker: waits for a completion signature, snapshots the register file and compares it against golden memory.
module regfile_golden_checker #(
  parameter int                XLEN           = 32,
  parameter int                NUM_REGS       = 32,
  parameter int                SIG_REG        = 11,
  parameter logic [XLEN-1:0]   SIG_VALUE      = 'h0000C0DE,
  parameter int unsigned       TIMEOUT_CYCLES = 50,
  parameter int                CNT_W          = 16,
  localparam int               IDX_W          = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NUM_REGS*XLEN-1:0] reg_flat,
  output logic                     gold_rd,
  output logic [IDX_W-1:0]         gold_addr,
  input  logic [XLEN-1:0]          gold_data,
  input  logic                     gold_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout,
  output logic [IDX_W:0]           mismatch_count,
  output logic [IDX_W-1:0]         first_bad_idx,
  output logic [XLEN-1:0]          first_bad_exp,
  output logic [XLEN-1:0]          first_bad_act,
  output logic [CNT_W-1:0]         wait_cycles
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CMP, S_FIN} state_t;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REGS - 1);
  state_t            r_state;
  logic [XLEN-1:0]   r_snap [NUM_REGS];
  logic              r_pend;
  logic [IDX_W-1:0]  r_pend_idx;
  logic              w_sig;
  logic              w_to;
  logic [31:0]       w_wc_p1;
  logic [XLEN-1:0]   w_act;
  logic              w_bad;
  logic [IDX_W:0]    w_cnt_nxt;
  always_comb begin
    w_sig     = reg_flat[SIG_REG*XLEN +: XLEN] == SIG_VALUE;
    w_wc_p1   = 32'(wait_cycles) + 32'd1;
    w_to      = (TIMEOUT_CYCLES != 0) && (w_wc_p1 == TIMEOUT_CYCLES);
    w_act     = r_snap[r_pend_idx];
    w_bad     = r_pend && gold_valid && (gold_data != w_act);
    w_cnt_nxt = mismatch_count + (IDX_W+1)'(w_bad);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_snap         <= '{default: '0};
      r_pend         <= 1'b0;
      r_pend_idx     <= '0;
      gold_rd        <= 1'b0;
      gold_addr      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      mismatch_count <= '0;
      first_bad_idx  <= '0;
      first_bad_exp  <= '0;
      first_bad_act  <= '0;
      wait_cycles    <= '0;
    end else begin
      // Compare stage trails the issue stage by one cycle, matching golden read latency.
      r_pend     <= gold_rd;
      r_pend_idx <= gold_addr;
      case (r_state)
        S_IDLE, S_FIN: if (start) begin
          r_state        <= S_WAIT;
          busy           <= 1'b1;
          done           <= 1'b0;
          pass           <= 1'b0;
          timeout        <= 1'b0;
          mismatch_count <= '0;
          first_bad_idx  <= '0;
          first_bad_exp  <= '0;
          first_bad_act  <= '0;
          wait_cycles    <= '0;
        end
        S_WAIT: if (w_sig || w_to) begin
          r_state   <= S_CMP;
          timeout   <= !w_sig;
          gold_rd   <= 1'b1;
          gold_addr <= '0;
          for (int i = 0; i < NUM_REGS; i++) r_snap[i] <= reg_flat[i*XLEN +: XLEN];
        end else begin
          wait_cycles <= (&wait_cycles) ? wait_cycles : wait_cycles + CNT_W'(1);
        end
        S_CMP: begin
          if (gold_rd) begin
            gold_rd   <= gold_addr != LAST;
            gold_addr <= (gold_addr == LAST) ? gold_addr : gold_addr + IDX_W'(1);
          end
          if (r_pend) begin
            mismatch_count <= w_cnt_nxt;
            if (w_bad && mismatch_count == '0) begin
              first_bad_idx <= r_pend_idx;
              first_bad_exp <= gold_data;
              first_bad_act <= w_act;
            end
            if (r_pend_idx == LAST) begin
              r_state <= S_FIN;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (w_cnt_nxt == '0) && !timeout;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
